// File: rtl/md_scheduler.sv
// HI/LO multiply/divide sequencer: computes the result at issue, then holds it
// pending for a fixed latency before committing to the architectural HI/LO.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MdRead,
  input  logic        D_UseMd,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MdOut
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_pend_hi, r_pend_lo, r_hi, r_lo;
  logic          r_pend_we;

  logic          w_is_md;
  logic          w_sgn;
  logic [63:0]   w_sprod, w_uprod;
  logic [31:0]   w_amag, w_bmag, w_dvd, w_dvs;
  logic [31:0]   w_q, w_r, w_quo, w_rem;
  logic [31:0]   w_res_hi, w_res_lo;

  assign w_is_md = (MdOp == 3'd1) || (MdOp == 3'd2) || (MdOp == 3'd3) || (MdOp == 3'd4);
  assign w_sgn   = (MdOp == 3'd3);

  assign w_sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_uprod = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow.
  assign w_amag = A[31] ? (~A + 32'd1) : A;
  assign w_bmag = B[31] ? (~B + 32'd1) : B;
  assign w_dvd  = w_sgn ? w_amag : A;
  assign w_dvs  = (B == '0) ? 32'd1 : (w_sgn ? w_bmag : B);
  assign w_q    = w_dvd / w_dvs;
  assign w_r    = w_dvd % w_dvs;
  assign w_quo  = (w_sgn && (A[31] ^ B[31])) ? (~w_q + 32'd1) : w_q;
  assign w_rem  = (w_sgn && A[31]) ? (~w_r + 32'd1) : w_r;

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (MdOp)
      3'd1:          {w_res_hi, w_res_lo} = w_sprod;
      3'd2:          {w_res_hi, w_res_lo} = w_uprod;
      3'd3, 3'd4: begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            if (w_is_md) begin
              r_pend_hi <= w_res_hi;
              r_pend_lo <= w_res_lo;
              r_state   <= RUN;
              if ((MdOp == 3'd1) || (MdOp == 3'd2)) begin
                r_cnt     <= CW'(MULT_CYCLES);
                r_pend_we <= 1'b1;
              end else begin
                r_cnt     <= CW'(DIV_CYCLES);
                r_pend_we <= (B != '0);
              end
            end else if (MdOp == 3'd5) begin
              r_hi <= A;
            end else if (MdOp == 3'd6) begin
              r_lo <= A;
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (r_pend_we) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy  = (r_state == RUN);
  assign Stall = D_UseMd & (Busy | (Start & w_is_md));
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign MdOut = MdRead ? r_hi : r_lo;

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: directed test-plan cases followed by random traffic,
// all checked against a cycle-stamped behavioural model of HI/LO.
module tb_md_scheduler;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MdOp = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        MdRead = 1'b0;
  logic        D_UseMd = 1'b0;
  logic        Busy, Stall;
  logic [31:0] HI, LO, MdOut;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MdOp(MdOp), .A(A), .B(B),
    .MdRead(MdRead), .D_UseMd(D_UseMd), .Busy(Busy), .Stall(Stall),
    .HI(HI), .LO(LO), .MdOut(MdOut)
  );

  always #5 clk = ~clk;

  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(Start && Busy))
    else $error("start issued while busy");

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;

  // Model: committed HI/LO, plus a pending result and the edge index at which it lands.
  logic [31:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;
  bit          m_we = 1'b0;
  bit          m_busy = 1'b0;
  int          m_done = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  task automatic compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ph, output logic [31:0] pl, output bit we);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ph = '0; pl = '0; we = 1'b1;
    case (op)
      3'd1: begin sp = sa * sb; ph = sp[63:32]; pl = sp[31:0]; end
      3'd2: begin up = 64'(a) * 64'(b); ph = up[63:32]; pl = up[31:0]; end
      3'd3: begin
        if (b == 0) we = 1'b0;
        else begin sq = sa / sb; sr = sa % sb; pl = sq[31:0]; ph = sr[31:0]; end
      end
      default: begin
        if (b == 0) we = 1'b0;
        else begin pl = a / b; ph = a % b; end
      end
    endcase
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_we = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (cyc == m_done) begin
        if (m_we) begin m_hi = m_ph; m_lo = m_pl; end
        m_busy = 1'b0;
      end
    end else if (st) begin
      if (is_md(op)) begin
        compute(op, a, b, m_ph, m_pl, m_we);
        m_busy = 1'b1;
        m_done = cyc + int'((op <= 3'd2) ? MC : DC);
      end else if (op == 3'd5) m_hi = a;
      else if (op == 3'd6) m_lo = a;
    end
    cyc++;
  endtask

  task automatic step(input logic rst, input logic st, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit do_chk);
    @(negedge clk);
    reset = rst; Start = st; MdOp = op; A = a; B = b;
    #1;
    if (do_chk) begin
      chk("busy", 32'(Busy), 32'(m_busy));
      chk("stall", 32'(Stall), 32'(D_UseMd & (m_busy | (st & is_md(op)))));
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
      chk("mdout", MdOut, MdRead ? m_hi : m_lo);
    end
    if (Stall) stall_cnt++;
    @(posedge clk);
    model_edge(rst, st, op, a, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, '0, 1'b1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    step(1'b0, 1'b1, op, a, b, 1'b1);
    idle(int'((op <= 3'd2) ? MC : DC));
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    idle(1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_mdout", MdOut, 32'd0);

    run_op(3'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy_end", 32'(Busy), 32'd0);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFA);

    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);

    run_op(3'd4, 32'd7, 32'd2);
    chk("divu_hi", HI, 32'd1);
    chk("divu_lo", LO, 32'd3);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_hi", HI, 32'hFFFFFFFF);
    chk("div_lo", LO, 32'hFFFFFFFD);

    run_op(3'd3, 32'd5, 32'd0);
    chk("div0_hi", HI, 32'hFFFFFFFF);
    chk("div0_lo", LO, 32'hFFFFFFFD);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf_hi", HI, 32'h0);
    chk("divovf_lo", LO, 32'h80000000);

    D_UseMd = 1'b1;
    stall_cnt = 0;
    run_op(3'd1, 32'd2, 32'd3);
    idle(2);
    chk("stall_total_use1", 32'(stall_cnt), 32'd6);
    D_UseMd = 1'b0;
    stall_cnt = 0;
    run_op(3'd1, 32'd2, 32'd3);
    idle(2);
    chk("stall_total_use0", 32'(stall_cnt), 32'd0);

    step(1'b0, 1'b1, 3'd5, 32'h12345678, '0, 1'b1);
    MdRead = 1'b1;
    #1 chk("mthi_out", MdOut, 32'h12345678);
    step(1'b0, 1'b1, 3'd6, 32'h9ABCDEF0, '0, 1'b1);
    MdRead = 1'b0;
    #1 chk("mtlo_out", MdOut, 32'h9ABCDEF0);
    chk("mtx_busy", 32'(Busy), 32'd0);

    step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1);
    #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    idle(12);
    chk("midrst_nocommit", HI | LO, 32'd0);
    run_op(3'd1, 32'd3, 32'd4);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd12);

    for (int i = 0; i < 3000; i++) begin
      logic       rst, st;
      logic [2:0] op;
      D_UseMd = 1'($urandom_range(0, 1));
      MdRead  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) == 0);
      st  = !m_busy && ($urandom_range(0, 2) == 0);
      op  = 3'($urandom_range(0, 7));
      step(rst, st, op, rnd32(), rnd32(), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multi-cycle multiply/divide sequencer for the pipelined MIPS core. It sits beside the E-stage ALU and accepts mult/multu/div/divu/mthi/mtlo from the E stage. It holds the HI/LO registers and models fixed multiply/divide latencies with a busy counter. It raises a stall request to the hazard unit whenever the D-stage instruction needs the HI/LO resource while the unit is occupied.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `Start` input 1: E-stage instruction is an MD-class op, valid this cycle.
- `MdOp` input 3: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other codes are no-ops.
- `A` input 32: rs operand (dividend, multiplicand, or mthi/mtlo data).
- `B` input 32: rt operand.
- `MdRead` input 1: 0 selects LO, 1 selects HI for `MdOut` (mfhi/mflo).
- `D_UseMd` input 1: D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `Busy` output 1: a multi-cycle operation is in flight.
- `Stall` output 1: stall request to the hazard unit.
- `HI` output 32: architectural HI.
- `LO` output 32: architectural LO.
- `MdOut` output 32: `MdRead ? HI : LO`, combinational.

## Operation
- FSM states are IDLE and RUN. Registers are `cnt` (4 bits, sized for the larger parameter), `pend_hi`/`pend_lo` (32 bits each), `pend_we` (1 bit), and `HI`/`LO`.
- In IDLE with `Start` and MdOp 1–4:
  - Latch the result into `pend_*` and load `cnt` with the op latency.
  - Go to RUN.
- Result computation:
  - mult is a signed 64-bit product; multu is unsigned. HI = product[63:32], LO = product[31:0].
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B==0):
  - `pend_we`=0, so HI/LO stay unchanged.
  - The full `DIV_CYCLES` busy period still elapses.
- In IDLE with `Start` and MdOp 5/6:
  - HI (or LO) ← A at that edge.
  - No busy period; state stays IDLE.
- In RUN:
  - `cnt` decrements each cycle.
  - In the cycle where `cnt`==1: commit `pend_*` to HI/LO if `pend_we`, then return to IDLE.
- `Start` while in RUN is illegal, because `Stall` prevents it.
  - It is ignored: no state, counter or pending change.
  - Verification flags it with an assertion.
- `Stall = D_UseMd & (Busy | (Start & MdOp∈{1,2,3,4}))`, combinational.
- `Busy` = (state==RUN), registered.
- On `reset` (including mid-RUN):
  - State → IDLE; `cnt`, `pend_*`, HI and LO → 0.
  - The in-flight result is discarded.
- `MdOut` reflects the committed HI/LO only, never the pending values.

## Timing
- Reset values: `Busy`=0, `HI`=0, `LO`=0, `MdOut`=0. `Stall` = `D_UseMd & Start & MdOp∈{1..4}`, which is 0 when inputs are idle.
- `Start` for an op of latency N sampled at edge t:
  - `Busy`=1 for exactly N cycles after t.
  - HI/LO update at edge t+N, and `Busy` falls at the same edge.
  - mfhi/mflo in E at cycle t+N+1 reads the new value.
- mthi/mtlo sampled at edge t: new HI/LO visible from t+1 (`MdOut` after the edge).
- `Stall` is asserted in the `Start` cycle and for all N busy cycles when `D_UseMd`=1. It deasserts in the cycle after `Busy` falls, so the D-stage consumer reaches E with committed HI/LO.
- Back-to-back ops: a new `Start` is accepted in the first IDLE cycle, giving a minimum spacing of N+1 cycles.
- A `reset` asserted in any cycle overrides `Start` in the same cycle.

## Test plan
- Reset, then mult A=0xFFFFFFFE (−2), B=3 → `Busy` high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA; `Busy` low on cycle 6.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles. divu A=7, B=2 → LO=3, HI=1 after 10 cycles.
- div A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div with B=0 → `Busy` for 10 cycles; HI/LO unchanged.
- Stall: mult started while `D_UseMd`=1 → `Stall` high in the Start cycle plus 5 busy cycles (6 total), then low. With `D_UseMd`=0 → `Stall` stays 0 throughout.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles → `MdRead`=1 gives 0x12345678 and `MdRead`=0 gives 0x9ABCDEF0, one cycle after each; `Busy` never rises.
- Reset asserted at busy cycle 3 of a div → next cycle `Busy`=0, HI=LO=0, no later commit. A following mult completes normally in 5 cycles.
